// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage of the c61 pipeline.
//
// Sits between decode and execute and wraps the 8 x 6-bit register file.
// Each cycle it:
//   - drives the register file read selects straight from the decoded
//     instruction,
//   - forwards same-cycle writeback data onto the operand values,
//   - tracks in-flight destination registers in a scoreboard and stalls
//     on RAW and WAW hazards,
//   - latches operands into an output register that is handed to execute
//     over a valid/ready handshake.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   id_valid / id_ready          decode-side handshake
//   id_op, id_ra_sel, id_rb_sel  opcode and source selects
//   id_rw_sel, id_we             destination select and write flag
//   rf_ra_sel, rf_rb_sel         register file read selects (combinational)
//   rf_ra, rf_rb                 register file read data
//   wb_we, wb_sel, wb_data       writeback port (shared with the register file)
//   ex_valid / ex_ready          execute-side handshake
//   ex_op, ex_a, ex_b            latched opcode and operands
//   ex_rw_sel, ex_we             latched destination and write flag
//   flush                        synchronous pipeline flush
module operand_fetch #(
  parameter int DW  = 6,
  parameter int AW  = 3,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  output logic           id_ready,
  input  logic [OPW-1:0] id_op,
  input  logic [AW-1:0]  id_ra_sel,
  input  logic [AW-1:0]  id_rb_sel,
  input  logic [AW-1:0]  id_rw_sel,
  input  logic           id_we,
  output logic [AW-1:0]  rf_ra_sel,
  output logic [AW-1:0]  rf_rb_sel,
  input  logic [DW-1:0]  rf_ra,
  input  logic [DW-1:0]  rf_rb,
  input  logic           wb_we,
  input  logic [AW-1:0]  wb_sel,
  input  logic [DW-1:0]  wb_data,
  output logic           ex_valid,
  input  logic           ex_ready,
  output logic [OPW-1:0] ex_op,
  output logic [DW-1:0]  ex_a,
  output logic [DW-1:0]  ex_b,
  output logic [AW-1:0]  ex_rw_sel,
  output logic           ex_we,
  input  logic           flush
);

  localparam int NR = 1 << AW;

  // Scoreboard: one bit per register, set while a writer is in flight.
  logic [NR-1:0]  scoreboard_r;
  logic [NR-1:0]  scoreboard_next_s;

  logic           ex_valid_r;
  logic [OPW-1:0] ex_op_r;
  logic [DW-1:0]  ex_a_r;
  logic [DW-1:0]  ex_b_r;
  logic [AW-1:0]  ex_rw_sel_r;
  logic           ex_we_r;

  logic [DW-1:0]  a_val_s;
  logic [DW-1:0]  b_val_s;
  logic           hazard_s;
  logic           id_ready_s;
  logic           accept_s;

  // A register is pending if it has an in-flight writer that is not
  // retiring on the writeback port this very cycle.
  function automatic logic reg_pending(
    input logic [NR-1:0] sb,
    input logic [AW-1:0] sel,
    input logic          wbe,
    input logic [AW-1:0] wbs
  );
    return sb[sel] && !(wbe && (wbs == sel));
  endfunction

  // Read selects go straight to the register file.
  assign rf_ra_sel = id_ra_sel;
  assign rf_rb_sel = id_rb_sel;

  // Operand bypass, hazard detection and the decode-side handshake.
  always_comb begin
    a_val_s    = rf_ra;
    b_val_s    = rf_rb;
    hazard_s   = 1'b0;
    id_ready_s = 1'b0;
    accept_s   = 1'b0;

    if (wb_we && (wb_sel == id_ra_sel)) begin
      a_val_s = wb_data;
    end else begin
      a_val_s = rf_ra;
    end

    if (wb_we && (wb_sel == id_rb_sel)) begin
      b_val_s = wb_data;
    end else begin
      b_val_s = rf_rb;
    end

    // Sources are checked regardless of opcode; the destination only
    // matters when the instruction actually writes it (WAW).
    hazard_s = reg_pending(scoreboard_r, id_ra_sel, wb_we, wb_sel) ||
               reg_pending(scoreboard_r, id_rb_sel, wb_we, wb_sel) ||
               (id_we && reg_pending(scoreboard_r, id_rw_sel, wb_we, wb_sel));

    // The output register may be refilled in the same cycle it drains.
    id_ready_s = !flush && !hazard_s && (!ex_valid_r || ex_ready);
    accept_s   = id_valid && id_ready_s;
  end

  // Next scoreboard value: clear on writeback, set on an accepted writer;
  // set takes priority when both hit the same register.
  always_comb begin
    scoreboard_next_s = scoreboard_r;
    for (int r = 0; r < NR; r++) begin
      if (accept_s && id_we && (id_rw_sel == AW'(r))) begin
        scoreboard_next_s[r] = 1'b1;
      end else if (wb_we && (wb_sel == AW'(r))) begin
        scoreboard_next_s[r] = 1'b0;
      end else begin
        scoreboard_next_s[r] = scoreboard_r[r];
      end
    end
  end

  // Scoreboard register; a flush forgets every in-flight writer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scoreboard_r <= {NR{1'b0}};
    end else if (flush) begin
      scoreboard_r <= {NR{1'b0}};
    end else begin
      scoreboard_r <= scoreboard_next_s;
    end
  end

  // Execute-side output register; data holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r  <= 1'b0;
      ex_op_r     <= {OPW{1'b0}};
      ex_a_r      <= {DW{1'b0}};
      ex_b_r      <= {DW{1'b0}};
      ex_rw_sel_r <= {AW{1'b0}};
      ex_we_r     <= 1'b0;
    end else if (flush) begin
      ex_valid_r  <= 1'b0;
    end else if (accept_s) begin
      ex_valid_r  <= 1'b1;
      ex_op_r     <= id_op;
      ex_a_r      <= a_val_s;
      ex_b_r      <= b_val_s;
      ex_rw_sel_r <= id_rw_sel;
      ex_we_r     <= id_we;
    end else if (ex_valid_r && ex_ready) begin
      ex_valid_r  <= 1'b0;
    end else begin
      ex_valid_r  <= ex_valid_r;
    end
  end

  assign id_ready  = id_ready_s;
  assign ex_valid  = ex_valid_r;
  assign ex_op     = ex_op_r;
  assign ex_a      = ex_a_r;
  assign ex_b      = ex_b_r;
  assign ex_rw_sel = ex_rw_sel_r;
  assign ex_we     = ex_we_r;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch.
module tb_operand_fetch;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic       id_ready;
  logic [3:0] id_op;
  logic [2:0] id_ra_sel;
  logic [2:0] id_rb_sel;
  logic [2:0] id_rw_sel;
  logic       id_we;
  logic [2:0] rf_ra_sel;
  logic [2:0] rf_rb_sel;
  logic [5:0] rf_ra;
  logic [5:0] rf_rb;
  logic       wb_we;
  logic [2:0] wb_sel;
  logic [5:0] wb_data;
  logic       ex_valid;
  logic       ex_ready;
  logic [3:0] ex_op;
  logic [5:0] ex_a;
  logic [5:0] ex_b;
  logic [2:0] ex_rw_sel;
  logic       ex_we;
  logic       flush;

  int n_checks = 0;
  int n_fails  = 0;

  operand_fetch #(.DW(6), .AW(3), .OPW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_op     (id_op),
    .id_ra_sel (id_ra_sel),
    .id_rb_sel (id_rb_sel),
    .id_rw_sel (id_rw_sel),
    .id_we     (id_we),
    .rf_ra_sel (rf_ra_sel),
    .rf_rb_sel (rf_rb_sel),
    .rf_ra     (rf_ra),
    .rf_rb     (rf_rb),
    .wb_we     (wb_we),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_op     (ex_op),
    .ex_a      (ex_a),
    .ex_b      (ex_b),
    .ex_rw_sel (ex_rw_sel),
    .ex_we     (ex_we),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rw, input logic we);
    id_valid  = v;
    id_op     = op;
    id_ra_sel = ra;
    id_rb_sel = rb;
    id_rw_sel = rw;
    id_we     = we;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    drive(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0);
    rf_ra = 6'h00; rf_rb = 6'h00;
    wb_we = 1'b0; wb_sel = 3'd0; wb_data = 6'h00;
    #1;
    check("rst_ex_valid", {7'd0, ex_valid}, 8'h00);
    check("rst_ex_a", {2'd0, ex_a}, 8'h00);
    check("rst_ex_op", {4'd0, ex_op}, 8'h00);
    check("rst_scoreboard", dut.scoreboard_r, 8'h00);
    tick(); tick();
    rst = 1'b0;
    #1;

    // Basic accept: ra=2, rb=5, writes r3.
    drive(1'b1, 4'h9, 3'd2, 3'd5, 3'd3, 1'b1);
    rf_ra = 6'h11; rf_rb = 6'h22;
    #1;
    check("basic_ready", {7'd0, id_ready}, 8'h01);
    check("rf_ra_sel", {5'd0, rf_ra_sel}, 8'h02);
    check("rf_rb_sel", {5'd0, rf_rb_sel}, 8'h05);
    tick();
    check("basic_ex_valid", {7'd0, ex_valid}, 8'h01);
    check("basic_ex_a", {2'd0, ex_a}, 8'h11);
    check("basic_ex_b", {2'd0, ex_b}, 8'h22);
    check("basic_ex_rw", {5'd0, ex_rw_sel}, 8'h03);
    check("basic_ex_we", {7'd0, ex_we}, 8'h01);
    check("basic_ex_op", {4'd0, ex_op}, 8'h09);
    check("basic_sb", dut.scoreboard_r, 8'h08);

    // RAW on r3: stall until writeback, then bypass.
    drive(1'b1, 4'h5, 3'd3, 3'd0, 3'd1, 1'b0);
    rf_ra = 6'h3F; rf_rb = 6'h01;
    #1;
    check("raw_stall", {7'd0, id_ready}, 8'h00);
    tick();
    check("raw_drain_valid", {7'd0, ex_valid}, 8'h00);
    check("raw_still_stall", {7'd0, id_ready}, 8'h00);
    wb_we = 1'b1; wb_sel = 3'd3; wb_data = 6'h2A;
    #1;
    check("raw_wb_ready", {7'd0, id_ready}, 8'h01);
    tick();
    wb_we = 1'b0;
    check("raw_ex_valid", {7'd0, ex_valid}, 8'h01);
    check("raw_bypass_a", {2'd0, ex_a}, 8'h2A);
    check("raw_ex_b", {2'd0, ex_b}, 8'h01);
    check("raw_ex_op", {4'd0, ex_op}, 8'h05);
    check("raw_sb", dut.scoreboard_r, 8'h00);

    // WAW on r7.
    drive(1'b1, 4'h1, 3'd0, 3'd0, 3'd7, 1'b1);
    rf_ra = 6'h00; rf_rb = 6'h00;
    tick();
    check("waw_first_sb", dut.scoreboard_r, 8'h80);
    drive(1'b1, 4'h2, 3'd1, 3'd2, 3'd7, 1'b1);
    #1;
    check("waw_stall", {7'd0, id_ready}, 8'h00);
    tick();
    check("waw_drain_valid", {7'd0, ex_valid}, 8'h00);
    drive(1'b1, 4'h3, 3'd1, 3'd2, 3'd7, 1'b0);
    #1;
    check("waw_nowrite_ready", {7'd0, id_ready}, 8'h01);
    tick();
    check("waw_nowrite_valid", {7'd0, ex_valid}, 8'h01);
    check("waw_nowrite_we", {7'd0, ex_we}, 8'h00);
    check("waw_nowrite_rw", {5'd0, ex_rw_sel}, 8'h07);
    check("waw_sb_kept", dut.scoreboard_r, 8'h80);

    // Backpressure for three cycles.
    ex_ready = 1'b0;
    drive(1'b1, 4'hA, 3'd1, 3'd2, 3'd0, 1'b0);
    rf_ra = 6'h05; rf_rb = 6'h06;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall", {7'd0, id_ready}, 8'h00);
      tick();
      check("bp_valid", {7'd0, ex_valid}, 8'h01);
      check("bp_op_hold", {4'd0, ex_op}, 8'h03);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_release_ready", {7'd0, id_ready}, 8'h01);
    tick();
    check("bp_new_op", {4'd0, ex_op}, 8'h0A);
    check("bp_new_a", {2'd0, ex_a}, 8'h05);
    check("bp_new_b", {2'd0, ex_b}, 8'h06);

    // Retire r7 with no accept.
    drive(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0);
    wb_we = 1'b1; wb_sel = 3'd7; wb_data = 6'h3C;
    tick();
    wb_we = 1'b0;
    check("retire_sb", dut.scoreboard_r, 8'h00);
    check("retire_valid", {7'd0, ex_valid}, 8'h00);

    // Simultaneous set and clear on r4.
    drive(1'b1, 4'h4, 3'd0, 3'd0, 3'd4, 1'b1);
    tick();
    check("sc_first_sb", dut.scoreboard_r, 8'h10);
    drive(1'b1, 4'h6, 3'd4, 3'd4, 3'd4, 1'b1);
    wb_we = 1'b1; wb_sel = 3'd4; wb_data = 6'h15;
    #1;
    check("sc_ready", {7'd0, id_ready}, 8'h01);
    tick();
    wb_we = 1'b0;
    check("sc_sb_kept", dut.scoreboard_r, 8'h10);
    check("sc_bypass_a", {2'd0, ex_a}, 8'h15);
    check("sc_bypass_b", {2'd0, ex_b}, 8'h15);

    // Fill the scoreboard, then flush.
    for (int r = 0; r < 8; r++) begin
      if (r != 4) begin
        drive(1'b1, 4'h7, 3'(r), 3'(r), 3'(r), 1'b1);
        tick();
      end
    end
    check("fill_sb", dut.scoreboard_r, 8'hFF);
    check("fill_valid", {7'd0, ex_valid}, 8'h01);
    flush = 1'b1;
    drive(1'b1, 4'h8, 3'd0, 3'd0, 3'd0, 1'b0);
    #1;
    check("flush_ready", {7'd0, id_ready}, 8'h00);
    tick();
    flush = 1'b0;
    drive(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0);
    check("flush_valid", {7'd0, ex_valid}, 8'h00);
    check("flush_sb", dut.scoreboard_r, 8'h00);
    #1;
    check("flush_after_ready", {7'd0, id_ready}, 8'h01);

    // Reset asserted mid-stall.
    ex_ready = 1'b0;
    drive(1'b1, 4'hB, 3'd0, 3'd0, 3'd2, 1'b1);
    rf_ra = 6'h12; rf_rb = 6'h34;
    tick();
    drive(1'b1, 4'hC, 3'd2, 3'd0, 3'd1, 1'b0);
    #1;
    check("rst_mid_stall", {7'd0, id_ready}, 8'h00);
    check("rst_mid_valid", {7'd0, ex_valid}, 8'h01);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {7'd0, ex_valid}, 8'h00);
    check("async_rst_a", {2'd0, ex_a}, 8'h00);
    check("async_rst_op", {4'd0, ex_op}, 8'h00);
    check("async_rst_sb", dut.scoreboard_r, 8'h00);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {7'd0, id_ready}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
